// File: rtl/serial_fas_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// Optional overflow output is enabled with SERIAL_FAS_OVF_EN.
package serial_fas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/serial_fas_ctrl_if.sv
// Request/response bundle between a requester and serial_fas_ctrl.
// The overflow signal exists only when SERIAL_FAS_OVF_EN is defined.
interface serial_fas_ctrl_if #(
  parameter int WIDTH = 8
);
  // Handshake: start is sampled only while idle (busy=0, done=0); the operands
  // and mode are captured on that edge. busy stays high while the operation
  // runs, then done pulses for one cycle with result/carry_out valid and held
  // until the next done. A start seen while busy or done is dropped.
  logic             start;
  logic             a_ns;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef SERIAL_FAS_OVF_EN
  logic             overflow;
`endif

  modport master (
    output start, a_ns, a_in, b_in,
`ifdef SERIAL_FAS_OVF_EN
    input  overflow,
`endif
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, a_ns, a_in, b_in,
`ifdef SERIAL_FAS_OVF_EN
    output overflow,
`endif
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/fas.sv
// Gate-level one-bit full adder / full subtractor slice.
// a_ns=1: s=a+b+cin with carry out; a_ns=0: s=a-b-cin with borrow out.
module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);
  logic x;
  logic a_eff;
  logic x_eff;

  // Subtraction reuses the carry equation with a and (a^b) inverted,
  // which turns generate/propagate into borrow-generate/borrow-propagate.
  assign x     = a ^ b;
  assign s     = x ^ cin;
  assign a_eff = ~(a ^ a_ns);
  assign x_eff = ~(x ^ a_ns);
  assign cout  = (a_eff & b) | (cin & x_eff);
endmodule

// File: rtl/serial_fas_ctrl.sv
// Bit-serial add/subtract controller driving a single fas slice, LSB first.
// Define SERIAL_FAS_OVF_EN to add the registered two's-complement overflow flag.
module serial_fas_ctrl
  import serial_fas_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_fas_ctrl_if.slave     bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             mode;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             s;
  logic             cout;
  logic [WIDTH-1:0] r_next;

  fas u_fas (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .a_ns (mode),
    .s    (s),
    .cout (cout)
  );

  assign r_next = {s, r_sh[WIDTH-1:1]};

`ifdef SERIAL_FAS_OVF_EN
  logic msb_a;
  logic msb_b;
  logic overflow_q;
  logic ovf_next;

  // Final s is the result MSB; overflow compares sign bits captured at load.
  assign ovf_next = (mode == MODE_ADD) ? ((msb_a == msb_b) && (s != msb_a))
                                       : ((msb_a != msb_b) && (s != msb_a));

  always_ff @(posedge clk) begin
    if (rst) begin
      msb_a      <= 1'b0;
      msb_b      <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      msb_a <= bus.a_in[WIDTH-1];
      msb_b <= bus.b_in[WIDTH-1];
    end else if (state == S_RUN && cnt == LAST_BIT) begin
      overflow_q <= ovf_next;
    end
  end

  assign bus.overflow = overflow_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      r_sh        <= '0;
      mode        <= 1'b0;
      carry       <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a_in;
            b_sh  <= bus.b_in;
            mode  <= bus.a_ns;
            carry <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sh  <= r_next;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            result_q    <= r_next;
            carry_out_q <= cout;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_RUN);
  assign bus.done      = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_serial_fas_ctrl.sv
// Self-checking bench for serial_fas_ctrl (WIDTH=8, 20-unit clock).
// Overflow checks are compiled in when SERIAL_FAS_OVF_EN is defined.
module tb_serial_fas_ctrl;
  import serial_fas_pkg::*;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  serial_fas_ctrl_if #(.WIDTH(W)) bus ();

  serial_fas_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // scoreboard entry: {overflow, carry_out, result}
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_result;

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic m);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c;
    logic         ov;
    if (m == MODE_ADD) begin
      sum = {1'b0, a} + {1'b0, b};
      r   = sum[W-1:0];
      c   = sum[W];
      ov  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r  = a - b;
      c  = (a < b);
      ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {ov, c, r};
  endfunction

  // driver: present a request for one edge, push its expected outcome
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.a_ns  = m;
    exp_q.push_back(model(a, b, m));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = $urandom_range(0, 255);
    bus.b_in  = $urandom_range(0, 255);
    bus.a_ns  = $urandom_range(0, 1);
  endtask

  // bounded wait for done; counts busy cycles seen on the way
  task automatic wait_done(output int busy_cnt, output bit timed_out);
    busy_cnt  = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({bus.busy, bus.done, bus.carry_out} !== 3'b000 || bus.result !== '0) begin
      failed++;
      $display("FAIL reset_outputs: busy=%b done=%b carry=%b result=%h, want 0 0 0 00",
               bus.busy, bus.done, bus.carry_out, bus.result);
    end
    tests++;
    if (dbg_state !== IDLE) begin
      failed++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    last_result = '0;
  endtask

  task automatic test_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input bit check_busy);
    int           bc;
    bit           to;
    logic [W+1:0] e;
    issue(a, b, m);
    wait_done(bc, to);
    tests++;
    if (to) begin
      failed++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
      return;
    end
    if (check_busy) begin
      tests++;
      if (bc !== W) begin
        failed++;
        $display("FAIL %s_busy_cycles: got %0d want %0d", name, bc, W);
      end
    end
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL %s_sb_empty: done with no expected entry", name);
      return;
    end
    e = exp_q.pop_front();
    tests++;
    if (bus.result !== e[W-1:0] || bus.carry_out !== e[W]) begin
      failed++;
      $display("FAIL %s_result: got %h/c%b want %h/c%b", name, bus.result, bus.carry_out,
               e[W-1:0], e[W]);
    end
`ifdef SERIAL_FAS_OVF_EN
    tests++;
    if (bus.overflow !== e[W+1]) begin
      failed++;
      $display("FAIL %s_overflow: got %b want %b", name, bus.overflow, e[W+1]);
    end
`endif
    last_result = e[W-1:0];
  endtask

  task automatic test_add();
    test_op("add_3c_55", 8'h3C, 8'h55, MODE_ADD, 1'b1);
    tests++;
    if (last_result !== 8'h91) begin
      failed++;
      $display("FAIL add_3c_55_const: got %h want 91", last_result);
    end
    test_op("add_ff_01", 8'hFF, 8'h01, MODE_ADD, 1'b1);
  endtask

  task automatic test_back_to_back();
    int           bc;
    bit           to;
    logic [W+1:0] e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'hFF;
    bus.b_in  = 8'h01;
    bus.a_ns  = MODE_ADD;
    exp_q.push_back(model(8'hFF, 8'h01, MODE_ADD));
    @(negedge clk);
    bus.a_in = 8'h00;
    bus.b_in = 8'h00;
    exp_q.push_back(model(8'h00, 8'h00, MODE_ADD));
    for (int k = 0; k < 2; k++) begin
      wait_done(bc, to);
      tests++;
      if (to || exp_q.size() == 0) begin
        failed++;
        $display("FAIL b2b_done_%0d: timeout=%b queue=%0d", k, to, exp_q.size());
        bus.start = 1'b0;
        return;
      end
      e = exp_q.pop_front();
      tests++;
      if (bus.result !== e[W-1:0] || bus.carry_out !== e[W]) begin
        failed++;
        $display("FAIL b2b_result_%0d: got %h/c%b want %h/c%b", k, bus.result,
                 bus.carry_out, e[W-1:0], e[W]);
      end
      last_result = e[W-1:0];
      if (k == 0) begin
        repeat (2) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
          failed++;
          $display("FAIL b2b_reaccept: busy=%b want 1", bus.busy);
        end
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_sub();
    test_op("sub_50_30", 8'h50, 8'h30, MODE_SUB, 1'b1);
    test_op("sub_10_20", 8'h10, 8'h20, MODE_SUB, 1'b1);
  endtask

  task automatic test_ignore_start();
    int           bc;
    bit           to;
    logic [W+1:0] e;
    logic [W-1:0] prev;
    prev = last_result;
    issue(8'h3C, 8'h55, MODE_ADD);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'h01;
    bus.b_in  = 8'h01;
    bus.a_ns  = MODE_ADD;
    @(negedge clk);
    bus.start = 1'b0;
    tests++;
    if (bus.result !== prev) begin
      failed++;
      $display("FAIL ignore_hold: result=%h want %h", bus.result, prev);
    end
    wait_done(bc, to);
    tests++;
    if (to || exp_q.size() == 0) begin
      failed++;
      $display("FAIL ignore_done: timeout=%b queue=%0d", to, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    tests++;
    if (bus.result !== e[W-1:0] || bus.carry_out !== e[W]) begin
      failed++;
      $display("FAIL ignore_result: got %h/c%b want %h/c%b", bus.result, bus.carry_out,
               e[W-1:0], e[W]);
    end
    last_result = e[W-1:0];
    repeat (W + 2) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failed++;
      $display("FAIL ignore_no_extra: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_mid_reset();
    int seen_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'h3C;
    bus.b_in  = 8'h55;
    bus.a_ns  = MODE_ADD;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({bus.busy, bus.done, bus.carry_out} !== 3'b000 || bus.result !== '0) begin
      failed++;
      $display("FAIL midrst_outputs: busy=%b done=%b carry=%b result=%h, want 0 0 0 00",
               bus.busy, bus.done, bus.carry_out, bus.result);
    end
    seen_done = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    tests++;
    if (seen_done !== 0) begin
      failed++;
      $display("FAIL midrst_no_done: got %0d done pulses want 0", seen_done);
    end
    last_result = '0;
    test_op("add_12_34", 8'h12, 8'h34, MODE_ADD, 1'b1);
  endtask

  task automatic test_overflow();
    test_op("ovf_7f_01", 8'h7F, 8'h01, MODE_ADD, 1'b0);
    test_op("ovf_80_01", 8'h80, 8'h01, MODE_SUB, 1'b0);
    test_op("ovf_05_03", 8'h05, 8'h03, MODE_ADD, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      test_op("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_ns  = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_sub();
    test_ignore_start();
    test_mid_reset();
    test_overflow();
    test_random();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL sb_leftover: %0d expected results never produced", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_fas_ctrl.md
Name: serial_fas_ctrl

Overview:
- Bit-serial add/subtract controller that time-multiplexes a single `fas` full adder/subtractor slice over WIDTH-bit operands.
- Latches two operands and a mode bit, then feeds one bit per clock (LSB first) through the slice.
- Holds carry/borrow in a flip-flop between bits, shifts sum bits into a result register, and signals completion with a `done` pulse.
- Sits between a requester (testbench or sequencer) and the gate-level arithmetic slice.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock. Period ≥ 20 time units; `fas` worst path is 13.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_ns  input  1  mode; 1 = add, 0 = subtract (A − B). Latched with start.
- a_in  input  WIDTH  operand A; latched with start.
- b_in  input  WIDTH  operand B; latched with start.
- busy  output  1  high from the cycle after start is accepted until done is high.
- done  output  1  one-cycle pulse; result and carry_out valid from this cycle.
- result  output  WIDTH  A+B or A−B, modulo 2^WIDTH; held until the next done.
- carry_out  output  1  add: unsigned carry; subtract: borrow (1 iff A < B unsigned). Held like result.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; busy=0, done=0, result=0, carry_out=0; internal shift registers, carry flop and bit counter cleared.
  - rst overrides everything, including mid-RUN; the in-flight operation is discarded and produces no done.
- States: IDLE, RUN, DONE; encoding from the package enum.
- IDLE:
  - start=1 at an edge: load A_sh←a_in, B_sh←b_in, mode←a_ns, carry←0, cnt←0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Slice inputs: a=A_sh[0], b=B_sh[0], cin=carry, a_ns=mode.
  - Each edge: R_sh←{s, R_sh[WIDTH-1:1]}; A_sh and B_sh shift right by 1; carry←cout; cnt←cnt+1.
  - When cnt==WIDTH-1 at the edge: result←{s, R_sh[WIDTH-1:1]}, carry_out←cout; go to DONE.
  - Subtraction is borrow-chained: cin = borrow-in, initial 0. No operand inversion and no +1 injection.
- DONE: done=1, busy=0 for exactly one cycle; unconditionally go to IDLE.
- Latency:
  - start sampled at edge k → busy high cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1.
  - Next start is accepted at the edge ending the DONE cycle+1, i.e. in IDLE. Minimum initiation interval: WIDTH+2 cycles.
- Boundary conditions:
  - start in RUN or DONE: ignored; operands and mode unchanged.
  - Operand inputs may change freely after the accept edge.
  - start held high continuously: a new operation is accepted on each return to IDLE.
  - cnt width is $clog2(WIDTH) bits; it never wraps within an operation.

Optional Feature:
- Macro: SERIAL_FAS_OVF_EN.
- Defined: adds output port `overflow` (1 bit), registered with result and cleared by reset. Two's-complement overflow:
  - add: A[MSB]==B[MSB] and result[MSB]!=A[MSB].
  - sub: A[MSB]!=B[MSB] and result[MSB]!=A[MSB].
  - A/B MSBs are captured at load.
- Undefined: the port and its logic are absent.

Decomposition:
- Package `serial_fas_pkg`: state enum (IDLE, RUN, DONE); mode constants MODE_ADD=1'b1, MODE_SUB=1'b0.
- Sub-module: exactly one existing `fas` instance for the datapath bit. The controller adds no arithmetic logic of its own beyond the counter.

Test Plan (WIDTH=8, clk period 20):
- add 0x3C+0x55, start at edge k → done in cycle k+9, result=0x91, carry_out=0, busy high exactly 8 cycles.
- add 0xFF+0x01 → result=0x00, carry_out=1. Then back-to-back add 0x00+0x00 with start held → result=0x00, carry_out=0.
- sub 0x50−0x30 → result=0x20, carry_out=0. sub 0x10−0x20 → result=0xF0, carry_out=1.
- start with 0x3C+0x55, then pulse start with 0x01+0x01 at RUN cycle 3 → second request ignored; result=0x91, and the previous result is held until done.
- rst at RUN cycle 4 → next cycle busy=0, done=0, result=0x00, and no done ever appears for that operation. A following add 0x12+0x34 → 0x46.
- With SERIAL_FAS_OVF_EN:
  - 0x7F+0x01 → result=0x80, overflow=1.
  - 0x80−0x01 → result=0x7F, overflow=1.
  - 0x05+0x03 → overflow=0.
